// File: rtl/kuznyechik_pkg.sv
// -----------------------------------------------------------------------------
// kuznyechik_pkg
// Shared constants for the Kuznyechik (GOST R34.12-2015) datapath blocks:
//   XS_BLOCK_W : block width in bits (128)
//   XS_BYTES   : bytes per block (16)
//   PI         : forward pi substitution table, indexed by input byte
//   PI_INV     : inverse pi table, derived from PI at elaboration time
//   xs_state_e : control states of the byte-serial substitution stage
// -----------------------------------------------------------------------------
package kuznyechik_pkg;

    localparam int XS_BLOCK_W = 128;
    localparam int XS_BYTES   = 16;

    // Entry [0] sits leftmost so the table reads in natural order below.
    typedef logic [0:255][7:0] sbox_table_t;

    localparam sbox_table_t PI = {
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // Builds the inverse permutation so the two tables can never disagree.
    function automatic sbox_table_t pi_invert(input sbox_table_t fwd);
        sbox_table_t inv_tbl;
        inv_tbl = '0;
        for (int i = 0; i < 256; i++) begin
            inv_tbl[fwd[i]] = 8'(i);
        end
        return inv_tbl;
    endfunction

    localparam sbox_table_t PI_INV = pi_invert(PI);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,   // no block loaded since reset
        ST_BUSY = 2'b01,   // substituting one byte per enabled cycle
        ST_DONE = 2'b10    // result complete, frozen until next load
    } xs_state_e;

endpackage

// File: rtl/xs_stage_sbox_pi.sv
// -----------------------------------------------------------------------------
// sbox_pi
// Combinational single-byte pi substitution shared by the serial stage.
// Ports:
//   byte_s  : 8-bit input byte
//   inv_s   : 1 selects the inverse table (present only with XS_STAGE_INV_EN)
//   subst_s : 8-bit substituted byte
// Configuration macro: XS_STAGE_INV_EN
// -----------------------------------------------------------------------------
module sbox_pi
    import kuznyechik_pkg::*;
(
    input  logic [7:0] byte_s,
`ifdef XS_STAGE_INV_EN
    input  logic       inv_s,
`endif
    output logic [7:0] subst_s
);

    // Table lookup; the inverse table exists only in the inverse-capable build.
    always_comb begin
        subst_s = 8'h00;
`ifdef XS_STAGE_INV_EN
        if (inv_s) begin
            subst_s = PI_INV[byte_s];
        end else begin
            subst_s = PI[byte_s];
        end
`else
        subst_s = PI[byte_s];
`endif
    end

endmodule

// File: rtl/xs_stage.sv
// -----------------------------------------------------------------------------
// xs_stage
// Byte-serial Kuznyechik X+S stage: DO = S(DI xor KEY), one byte per enabled
// cycle through a single shared pi S-box, 16 enabled cycles per block.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   enable : advance processing by one byte
//   load   : capture a new block and start (wins over enable, aborts a block)
//   inv    : latched at load, selects S^-1 then key add (XS_STAGE_INV_EN only)
//   DI     : data block
//   KEY    : round key
//   DO     : state register; meaningful only while ready=1
//   ready  : DO holds the complete result
// Configuration macro: XS_STAGE_INV_EN adds the inverse mode.
// -----------------------------------------------------------------------------
module xs_stage
    import kuznyechik_pkg::*;
#(
    parameter int W = XS_BLOCK_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         load,
`ifdef XS_STAGE_INV_EN
    input  logic         inv,
`endif
    input  logic [W-1:0] DI,
    input  logic [W-1:0] KEY,
    output logic [W-1:0] DO,
    output logic         ready
);

    localparam logic [4:0] LAST_CNT = 5'(XS_BYTES - 1);

    xs_state_e    fsm_r;
    xs_state_e    fsm_nxt_s;
    logic [W-1:0] data_r;
    logic [W-1:0] data_nxt_s;
    logic [4:0]   cnt_r;
    logic [4:0]   cnt_nxt_s;
    logic         ready_r;
    logic         ready_nxt_s;
    logic [7:0]   sbox_out_s;
    logic [W-1:0] rot_s;
    logic [W-1:0] load_val_s;
    logic [W-1:0] final_mask_s;

`ifdef XS_STAGE_INV_EN
    logic         inv_r;
    logic [W-1:0] key_r;

    // Mode and key are held for the whole block so the final key add uses
    // the key present at load, not whatever KEY carries later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inv_r <= 1'b0;
            key_r <= '0;
        end else if (load) begin
            inv_r <= inv;
            key_r <= KEY;
        end else begin
            inv_r <= inv_r;
            key_r <= key_r;
        end
    end

    // Inverse mode substitutes the raw block and adds the key on the last byte.
    always_comb begin
        load_val_s   = DI ^ KEY;
        final_mask_s = '0;
        if (inv) begin
            load_val_s = DI;
        end else begin
            load_val_s = DI ^ KEY;
        end
        if (inv_r) begin
            final_mask_s = key_r;
        end else begin
            final_mask_s = '0;
        end
    end
`else
    // Forward-only build: key is folded in at capture, nothing added at the end.
    always_comb begin
        load_val_s   = DI ^ KEY;
        final_mask_s = '0;
    end
`endif

    sbox_pi u_sbox_pi (
        .byte_s  (data_r[W-1 -: 8]),
`ifdef XS_STAGE_INV_EN
        .inv_s   (inv_r),
`endif
        .subst_s (sbox_out_s)
    );

    // Top byte leaves, its substitute enters at the bottom; after 16 steps
    // every byte is back in its original lane.
    assign rot_s = {data_r[W-9:0], sbox_out_s};

    // Next-state logic: load restarts, busy advances on enable, done freezes.
    always_comb begin
        fsm_nxt_s   = fsm_r;
        data_nxt_s  = data_r;
        cnt_nxt_s   = cnt_r;
        ready_nxt_s = ready_r;
        if (load) begin
            fsm_nxt_s   = ST_BUSY;
            data_nxt_s  = load_val_s;
            cnt_nxt_s   = 5'd0;
            ready_nxt_s = 1'b0;
        end else begin
            case (fsm_r)
                ST_BUSY: begin
                    if (enable) begin
                        cnt_nxt_s = cnt_r + 5'd1;
                        if (cnt_r == LAST_CNT) begin
                            data_nxt_s  = rot_s ^ final_mask_s;
                            fsm_nxt_s   = ST_DONE;
                            ready_nxt_s = 1'b1;
                        end else begin
                            data_nxt_s = rot_s;
                        end
                    end else begin
                        data_nxt_s = data_r;
                    end
                end
                ST_IDLE: begin
                    ready_nxt_s = 1'b0;
                end
                ST_DONE: begin
                    ready_nxt_s = 1'b1;
                end
                default: begin
                    // Unreachable encoding: fall back to idle with no result.
                    fsm_nxt_s   = ST_IDLE;
                    ready_nxt_s = 1'b0;
                end
            endcase
        end
    end

    // State, counter and result flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_r   <= ST_IDLE;
            data_r  <= '0;
            cnt_r   <= 5'd0;
            ready_r <= 1'b0;
        end else begin
            fsm_r   <= fsm_nxt_s;
            data_r  <= data_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ready_r <= ready_nxt_s;
        end
    end

    assign DO    = data_r;
    assign ready = ready_r;

endmodule

// File: tb/tb_xs_stage.sv
// -----------------------------------------------------------------------------
// tb_xs_stage
// Self-checking bench for xs_stage: directed known-answer vectors plus random
// blocks with random enable gaps, checked against a byte-wise table model.
// Build with XS_STAGE_INV_EN defined to also cover the inverse mode.
// -----------------------------------------------------------------------------
module tb_xs_stage;

    localparam logic [7:0] PI_REF [0:255] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    localparam logic [127:0] VEC_A   = 128'hffeeddccbbaa99881122334455667700;
    localparam logic [127:0] VEC_B   = 128'hb66cd8887d38e8d77765aeea0c9a7efc;
    localparam logic [127:0] VEC_C   = 128'h559d8dd7bd06cbfe7e7b262523280d39;
    localparam logic [127:0] VEC_K   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] VEC_FC  = 128'hfcfcfcfcfcfcfcfcfcfcfcfcfcfcfcfc;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         load;
    logic         inv;
    logic [127:0] DI;
    logic [127:0] KEY;
    logic [127:0] DO;
    logic         ready;

    int total;
    int bad;

    xs_stage #(.W(128)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .load   (load),
`ifdef XS_STAGE_INV_EN
        .inv    (inv),
`endif
        .DI     (DI),
        .KEY    (KEY),
        .DO     (DO),
        .ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: apply pi to every byte of the block independently.
    function automatic logic [127:0] s_fwd(input logic [127:0] x);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[b*8 +: 8] = PI_REF[x[b*8 +: 8]];
        return r;
    endfunction

    // Reference inverse: find the table position holding each byte.
    function automatic logic [127:0] s_inv(input logic [127:0] x);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            for (int v = 0; v < 256; v++) begin
                if (PI_REF[v] == x[b*8 +: 8]) r[b*8 +: 8] = 8'(v);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] expect_of(input logic [127:0] di, input logic [127:0] key,
                                               input bit inv_b);
        if (inv_b) return s_inv(di) ^ key;
        else       return s_fwd(di ^ key);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input logic [127:0] di, input logic [127:0] key, input bit inv_b);
        DI     = di;
        KEY    = key;
        inv    = inv_b;
        load   = 1'b1;
        enable = 1'b1;
        tick();
        load   = 1'b0;
        // The stage must not depend on DI/KEY/inv after the load edge.
        DI     = {$urandom(), $urandom(), $urandom(), $urandom()};
        KEY    = {$urandom(), $urandom(), $urandom(), $urandom()};
        inv    = 1'($urandom_range(0, 1));
    endtask

    // Load one block, stall stall_len cycles once stall_at bytes are done,
    // then check latency, ready and result.
    task automatic run_block(input string tag, input logic [127:0] di, input logic [127:0] key,
                             input bit inv_b, input int stall_at, input int stall_len);
        int en_cnt;
        int cyc;
        int stalled;
        logic [127:0] exp;
        exp = expect_of(di, key, inv_b);
        load_block(di, key, inv_b);
        check({tag, "_rdy_after_load"}, ready, 1'b0);
        en_cnt  = 0;
        cyc     = 0;
        stalled = 0;
        while (en_cnt < 16 && cyc < 100) begin
            if (en_cnt == stall_at && stalled < stall_len) begin
                enable = 1'b0;
                stalled++;
            end else begin
                enable = 1'b1;
            end
            tick();
            cyc++;
            if (enable) en_cnt++;
            check({tag, "_rdy"}, ready, en_cnt == 16);
        end
        check({tag, "_cycles"}, cyc, 16 + stall_len);
        check({tag, "_do"}, DO, exp);
        // Result must stay frozen whatever enable does.
        for (int i = 0; i < 4; i++) begin
            enable = 1'($urandom_range(0, 1));
            tick();
        end
        check({tag, "_rdy_hold"}, ready, 1'b1);
        check({tag, "_do_hold"}, DO, exp);
    endtask

    // Random block: possibly several load cycles, random enable gaps.
    task automatic rand_block();
        int n_load;
        int en_cnt;
        int cyc;
        bit inv_b;
        logic [127:0] di;
        logic [127:0] key;
        n_load = $urandom_range(1, 3);
        di     = '0;
        key    = '0;
        inv_b  = 1'b0;
        for (int k = 0; k < n_load; k++) begin
            di  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef XS_STAGE_INV_EN
            inv_b = 1'($urandom_range(0, 1));
`endif
            DI     = di;
            KEY    = key;
            inv    = inv_b;
            load   = 1'b1;
            enable = 1'($urandom_range(0, 1));
            tick();
            check("rnd_rdy_load", ready, 1'b0);
        end
        load   = 1'b0;
        inv    = 1'($urandom_range(0, 1));
        en_cnt = 0;
        cyc    = 0;
        while (en_cnt < 16 && cyc < 200) begin
            enable = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
            if (enable) en_cnt++;
            check("rnd_rdy", ready, en_cnt == 16);
        end
        check("rnd_do", DO, expect_of(di, key, inv_b));
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        inv    = 1'b0;
        DI     = '0;
        KEY    = '0;
        tick();
        tick();
        check("reset_do", DO, 128'd0);
        check("reset_rdy", ready, 1'b0);
        rst = 1'b1;

        // Enable without any load must not produce a result.
        enable = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("noload_rdy", ready, 1'b0);

        run_block("kat_a", VEC_A, 128'd0, 1'b0, 99, 0);
        run_block("kat_b", VEC_B, 128'd0, 1'b0, 99, 0);
        run_block("kat_k", VEC_K, VEC_K, 1'b0, 99, 0);
        check("kat_k_fc", DO, VEC_FC);
        run_block("stall", VEC_A, 128'd0, 1'b0, 6, 5);
        check("stall_vec", DO, VEC_B);

        // Abort: reload with the second vector after 9 enabled cycles.
        load_block(VEC_A, 128'd0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            enable = 1'b1;
            tick();
            check("abort_rdy", ready, 1'b0);
        end
        run_block("abort", VEC_B, 128'd0, 1'b0, 99, 0);
        check("abort_vec", DO, VEC_C);

        // Asynchronous reset mid-block, away from any clock edge.
        load_block(VEC_A, 128'd0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        check("arst_do", DO, 128'd0);
        check("arst_rdy", ready, 1'b0);
        tick();
        rst    = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("arst_stays_idle", ready, 1'b0);

`ifdef XS_STAGE_INV_EN
        run_block("inv_kat", VEC_B, 128'd0, 1'b1, 99, 0);
        check("inv_kat_vec", DO, VEC_A);
        run_block("inv_key", VEC_C, VEC_K, 1'b1, 3, 2);
`endif

        for (int n = 0; n < 30; n++) rand_block();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
